// File: rtl/fsd_marquee.sv
// Character buffer and scroller for the fourteen-segment display encoder.
// Keeps a circular buffer of characters and registers a DIGIT_COUNT-wide window,
// which is static while the text fits and scrolls once it does not.
module fsd_marquee #(
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int DIGIT_COUNT  = 4,
    parameter int CHAR_WIDTH   = 8,
    parameter int SCROLL_TICKS = 4,
    parameter int TICK_WIDTH   = 2
) (
    input  logic                              clk_ctrl,
    input  logic                              reset_n,
    input  logic [CHAR_WIDTH-1:0]             char_in,
    input  logic                              char_valid_n,
    input  logic                              clear_n,
    output logic [DIGIT_COUNT*CHAR_WIDTH-1:0] chars,
    output logic [ADDR_WIDTH:0]               count,
    output logic                              full
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CHAR_WIDTH-1:0] SPACE     = CHAR_WIDTH'(8'h20);
    localparam logic [CW-1:0]         ONE       = CW'(1);
    localparam logic [CW-1:0]         DIGITS    = CW'(DIGIT_COUNT);
    localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [TICK_WIDTH-1:0] TICK_ONE  = TICK_WIDTH'(1);
    localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(SCROLL_TICKS - 1);

    typedef enum logic {STATIC, SCROLL} state_t;
    state_t state, state_next;

    logic [CHAR_WIDTH-1:0]             mem [DEPTH];
    logic [ADDR_WIDTH-1:0]             head, tail;
    logic [CW-1:0]                     offset;
    logic [TICK_WIDTH-1:0]             tick;
    logic [CW-1:0]                     seq_len;
    logic [CW-1:0]                     elem, raw;
    logic [DIGIT_COUNT*CHAR_WIDTH-1:0] window;
    logic                              do_clear, do_write, step;

    assign full     = (count == DEPTH_C);
    assign do_clear = !clear_n;
    assign do_write = !char_valid_n && !full && clear_n;
    assign seq_len  = count + ONE;
    assign step     = (state == SCROLL) && (tick == TICK_LAST);

    always_ff @(posedge clk_ctrl or negedge reset_n) begin
        if (!reset_n) state <= STATIC;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (do_clear)
            state_next = STATIC;
        else if (state == STATIC && do_write && count == DIGITS)
            state_next = SCROLL;
    end

    // The offset wraps against the sequence length of the current cycle, so a
    // write landing on a step edge still sees the old length.
    always_ff @(posedge clk_ctrl or negedge reset_n) begin
        if (!reset_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            offset <= '0;
            tick   <= '0;
            chars  <= {DIGIT_COUNT{SPACE}};
        end else begin
            chars <= window;
            if (do_clear) begin
                head   <= '0;
                tail   <= '0;
                count  <= '0;
                offset <= '0;
                tick   <= '0;
            end else begin
                if (do_write) begin
                    tail  <= tail + PTR_ONE;
                    count <= count + ONE;
                end
                if (state == SCROLL) begin
                    if (step) begin
                        tick   <= '0;
                        offset <= (offset + ONE == seq_len) ? '0 : offset + ONE;
                    end else begin
                        tick <= tick + TICK_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_ctrl) begin
        if (do_write) mem[tail] <= char_in;
    end

    // In SCROLL the length exceeds DIGIT_COUNT, so one conditional subtract is a full modulo.
    always_comb begin
        window = {DIGIT_COUNT{SPACE}};
        elem   = '0;
        raw    = '0;
        for (int k = 0; k < DIGIT_COUNT; k++) begin
            if (state == STATIC) begin
                elem = count - ONE - CW'(k);
                if (CW'(k) < count)
                    window[k*CHAR_WIDTH +: CHAR_WIDTH] = mem[head + elem[ADDR_WIDTH-1:0]];
            end else begin
                raw  = offset + CW'(DIGIT_COUNT - 1 - k);
                elem = (raw >= seq_len) ? raw - seq_len : raw;
                if (elem != count)
                    window[k*CHAR_WIDTH +: CHAR_WIDTH] = mem[head + elem[ADDR_WIDTH-1:0]];
            end
        end
    end
endmodule
